// File: rtl/expansor_vizinhos_if.sv
// Bundles the node, read-manager and result handshakes of the neighbour expander.
// slave: expander side; master: the surrounding fabric (node source, read manager, sink).
interface expansor_vizinhos_if #(
  parameter int unsigned NUM_READ_PORTS = 8,
  parameter int unsigned DATA_WIDH      = 32,
  parameter int unsigned ADDR_WIDTH     = 8
);
  logic                                 node_valid_in;
  logic [ADDR_WIDTH-1:0]                node_addr_in;
  logic                                 node_ready_out;
  logic                                 read_en_out;
  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] read_addr_out;
  logic                                 ready_in;
  logic [DATA_WIDH*NUM_READ_PORTS-1:0]  read_data_in;
  logic                                 result_valid_out;
  logic [DATA_WIDH*NUM_READ_PORTS-1:0]  result_data_out;
  logic [NUM_READ_PORTS-1:0]            result_mask_out;
  logic                                 result_ready_in;
  logic [15:0]                          expand_count_out;

  modport slave (
    input  node_valid_in, node_addr_in, ready_in, read_data_in, result_ready_in,
    output node_ready_out, read_en_out, read_addr_out, result_valid_out,
    output result_data_out, result_mask_out, expand_count_out
  );

  modport master (
    output node_valid_in, node_addr_in, ready_in, read_data_in, result_ready_in,
    input  node_ready_out, read_en_out, read_addr_out, result_valid_out,
    input  result_data_out, result_mask_out, expand_count_out
  );
endinterface

// File: rtl/expansor_vizinhos.sv
// Neighbour expander: accepts a node, requests its NUM_READ_PORTS successor addresses,
// waits READ_LATENCY cycles after the grant, then presents the words with a validity mask.
module expansor_vizinhos #(
  parameter int unsigned NUM_READ_PORTS = 8,
  parameter int unsigned DATA_WIDH      = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1
) (
  input logic                clk,
  input logic                rst_n,
  expansor_vizinhos_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

  state_e                               state_q, state_d;
  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] addr_q, addr_d;
  logic [3:0]                           lat_q, lat_d;
  logic [DATA_WIDH*NUM_READ_PORTS-1:0]  data_q, data_d;
  logic [NUM_READ_PORTS-1:0]            mask_q, mask_d;
  logic [15:0]                          expand_count_q, expand_count_d;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    lat_d          = lat_q;
    data_d         = data_q;
    mask_d         = mask_q;
    expand_count_d = expand_count_q;
    unique case (state_q)
      StIdle: begin
        if (bus.node_valid_in) begin
          // Port p reads node+p+1; the add truncates so addresses wrap.
          for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
            addr_d[ADDR_WIDTH*p +: ADDR_WIDTH] = bus.node_addr_in + ADDR_WIDTH'(p + 1);
          end
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.ready_in) begin
          lat_d   = 4'(READ_LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) begin
          data_d = bus.read_data_in;
          // All-ones word is the no-neighbour marker.
          for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
            mask_d[p] = ~&bus.read_data_in[DATA_WIDH*p +: DATA_WIDH];
          end
          state_d = StOut;
        end
      end
      StOut: begin
        if (bus.result_ready_in) begin
          expand_count_d = expand_count_q + 16'd1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      lat_q          <= '0;
      data_q         <= '0;
      mask_q         <= '0;
      expand_count_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      lat_q          <= lat_d;
      data_q         <= data_d;
      mask_q         <= mask_d;
      expand_count_q <= expand_count_d;
    end
  end

  assign bus.node_ready_out   = (state_q == StIdle);
  assign bus.read_en_out      = (state_q == StReq);
  assign bus.read_addr_out    = addr_q;
  assign bus.result_valid_out = (state_q == StOut);
  assign bus.result_data_out  = data_q;
  assign bus.result_mask_out  = mask_q;
  assign bus.expand_count_out = expand_count_q;

endmodule
